// File: rtl/operand_fetch_scheduler_pkg.sv
// Shared types and address helpers for the operand fetch scheduler.
package operand_fetch_scheduler_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE_W = 3'd1,
    S_ISSUE_A = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } fsm_state_t;

  // Word-pair index of an activation in the feature-map region (before the x2 and +k).
  function automatic logic [31:0] act_offset(input logic [31:0] ch_in, input logic [31:0] x,
                                             input logic [31:0] y, input logic [31:0] ch_out,
                                             input logic [31:0] width, input logic [31:0] height,
                                             input logic [31:0] out_ch);
    return ((ch_in * width + x) * height + y) * out_ch + ch_out;
  endfunction

endpackage

// File: rtl/operand_fetch_scheduler_sync_fifo.sv
// Synchronous FIFO with a registered head word; a push into an empty FIFO is visible next cycle.
module sync_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic                      pop,
  output logic                      full,
  output logic                      valid,
  output logic [DATA_WIDTH-1:0]     head,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_next;
  logic [CW-1:0] remain, count_next;
  logic          do_push, do_pop;

  assign full = (count == CW'(DEPTH));

  always_comb begin
    do_pop     = pop & valid;
    do_push    = push & (~full | do_pop);
    rd_next    = rd_ptr + PW'(do_pop);
    remain     = count - CW'(do_pop);
    count_next = remain + CW'(do_push);
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      valid  <= 1'b0;
      head   <= '0;
    end else begin
      count  <= count_next;
      rd_ptr <= rd_next;
      valid  <= (count_next != '0);
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      // When nothing older survives the pop, the new head is the word arriving now.
      if (count_next != '0) head <= (remain == '0) ? wdata : mem[rd_next];
    end
  end
endmodule

// File: rtl/operand_fetch_scheduler.sv
// Fetches weight and activation operand pairs in controller consumption order, issuing
// external reads only when the output FIFO has room for every in-flight response.
module operand_fetch_scheduler
  import operand_fetch_scheduler_pkg::*;
#(
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int INPUT_NB_CHANNELS  = 64,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int LOG2_OF_MEM_HEIGHT = 20,
  parameter int DATA_WIDTH         = 16,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                          clk,
  input  logic                          arst_n_in,
  input  logic                          start,
  input  logic [LOG2_OF_MEM_HEIGHT-1:0] w_base,
  input  logic [LOG2_OF_MEM_HEIGHT-1:0] a_base,
  output logic                          running,
  output logic                          done,
  output logic                          ext_req,
  output logic [LOG2_OF_MEM_HEIGHT-1:0] ext_addr,
  input  logic                          ext_gnt,
  input  logic                          ext_rvalid,
  input  logic [DATA_WIDTH-1:0]         ext_rdata,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic                          err,
  output logic [2:0]                    fsm_state
);
  localparam int AW  = LOG2_OF_MEM_HEIGHT;
  localparam int XW  = (FEATURE_MAP_WIDTH  > 1) ? $clog2(FEATURE_MAP_WIDTH)  : 1;
  localparam int YW  = (FEATURE_MAP_HEIGHT > 1) ? $clog2(FEATURE_MAP_HEIGHT) : 1;
  localparam int CIW = (INPUT_NB_CHANNELS  > 1) ? $clog2(INPUT_NB_CHANNELS)  : 1;
  localparam int COW = (OUTPUT_NB_CHANNELS > 1) ? $clog2(OUTPUT_NB_CHANNELS) : 1;
  localparam int OW  = $clog2(FIFO_DEPTH) + 1;
  localparam int UW  = OW + 1;
  localparam logic [XW-1:0]  X_LAST  = XW'(FEATURE_MAP_WIDTH - 1);
  localparam logic [YW-1:0]  Y_LAST  = YW'(FEATURE_MAP_HEIGHT - 1);
  localparam logic [CIW-1:0] CI_LAST = CIW'(INPUT_NB_CHANNELS - 1);
  localparam logic [COW-1:0] CO_LAST = COW'(OUTPUT_NB_CHANNELS - 1);

  // Handshakes: ext transfer = ext_req & ext_gnt, and ext_req/ext_addr hold until granted;
  // output transfer = out_valid & out_ready; ext_rvalid is in order and cannot be stalled.
  fsm_state_t     state, adv_state;
  logic           k, nk;
  logic [CIW-1:0] ci, nci;
  logic [XW-1:0]  x, nx;
  logic [YW-1:0]  y, ny;
  logic [COW-1:0] co, nco;
  logic [AW-1:0]  w_base_q, a_base_q, cur_addr, nxt_addr;
  logic [OW-1:0]  outstanding, fifo_count;
  logic [UW-1:0]  used_next;
  logic           xfer, pop, rv_ok, rv_bad, push, credit_ok, fifo_full;

  function automatic logic [AW-1:0] addr_of(input logic is_w, input logic [CIW-1:0] c_i,
                                            input logic [XW-1:0] px, input logic [YW-1:0] py,
                                            input logic [COW-1:0] pco, input logic kk);
    logic [31:0] off;
    if (is_w) begin
      off = 32'd2 * 32'(c_i) + 32'(kk);
      return w_base_q + AW'(off);
    end
    off = 32'd2 * act_offset(32'(c_i), 32'(px), 32'(py), 32'(pco), 32'(FEATURE_MAP_WIDTH),
                             32'(FEATURE_MAP_HEIGHT), 32'(OUTPUT_NB_CHANNELS)) + 32'(kk);
    return a_base_q + AW'(off);
  endfunction

  assign xfer   = ext_req & ext_gnt;
  assign pop    = out_valid & out_ready;
  assign rv_ok  = ext_rvalid & (outstanding != '0);
  assign rv_bad = ext_rvalid & (outstanding == '0);
  assign push   = rv_ok & (~fifo_full | pop);
  // Pushes and responses cancel, so this is the FIFO + in-flight occupancy after this edge.
  assign used_next = UW'(fifo_count) + UW'(outstanding) + UW'(xfer) - UW'(pop);
  assign credit_ok = (used_next < UW'(FIFO_DEPTH));
  assign fsm_state = state;

  always_comb begin
    nk = ~k; nco = co; ny = y; nx = x; nci = ci; adv_state = state;
    if (k) begin
      if (state == S_ISSUE_W) adv_state = S_ISSUE_A;
      else if (co != CO_LAST) nco = co + COW'(1);
      else begin
        nco = '0;
        if (y != Y_LAST) ny = y + YW'(1);
        else begin
          ny = '0;
          if (x != X_LAST) nx = x + XW'(1);
          else begin
            nx = '0;
            if (ci != CI_LAST) begin
              nci = ci + CIW'(1);
              adv_state = S_ISSUE_W;
            end else adv_state = S_DRAIN;
          end
        end
      end
    end
  end

  assign cur_addr = addr_of(state == S_ISSUE_W, ci, x, y, co, k);
  assign nxt_addr = addr_of(adv_state == S_ISSUE_W, nci, nx, ny, nco, nk);

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state <= S_IDLE; running <= 1'b0; done <= 1'b0; err <= 1'b0;
      ext_req <= 1'b0; ext_addr <= '0; outstanding <= '0;
      k <= 1'b0; ci <= '0; x <= '0; y <= '0; co <= '0;
      w_base_q <= '0; a_base_q <= '0;
    end else begin
      done <= 1'b0;
      if (xfer && !rv_ok) outstanding <= outstanding + OW'(1);
      else if (!xfer && rv_ok) outstanding <= outstanding - OW'(1);
      if (rv_bad && running) err <= 1'b1;
      case (state)
        S_IDLE: if (start) begin
          state <= S_ISSUE_W; running <= 1'b1; err <= 1'b0;
          w_base_q <= w_base; a_base_q <= a_base;
          k <= 1'b0; ci <= '0; x <= '0; y <= '0; co <= '0;
          ext_req <= 1'b1; ext_addr <= w_base;
        end
        S_ISSUE_W, S_ISSUE_A: begin
          if (xfer) begin
            k <= nk; ci <= nci; x <= nx; y <= ny; co <= nco;
            state    <= adv_state;
            ext_req  <= (adv_state != S_DRAIN) && credit_ok;
            ext_addr <= nxt_addr;
          end else if (!ext_req && credit_ok) begin
            ext_req  <= 1'b1;
            ext_addr <= cur_addr;
          end
        end
        S_DRAIN: if (used_next == '0) begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state   <= S_IDLE;
          running <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (arst_n_in),
    .push  (push),
    .wdata (ext_rdata),
    .pop   (pop),
    .full  (fifo_full),
    .valid (out_valid),
    .head  (out_data),
    .count (fifo_count)
  );
endmodule

// File: tb/tb_operand_fetch_scheduler.sv
// Bench for operand_fetch_scheduler: latency-modelled memory, spec-level address reference, scoreboard.
module tb_operand_fetch_scheduler;
  localparam int W = 2, H = 2, OC = 2, IC = 2, AW = 20, DW = 16, DEPTH = 8, LAT = 2;
  localparam int WORDS = 2 * IC * (1 + W * H * OC);

  logic clk = 1'b0, arst_n_in = 1'b0, start = 1'b0;
  logic [AW-1:0] w_base = '0, a_base = '0, ext_addr;
  logic running, done, ext_req, out_valid, err;
  logic ext_gnt = 1'b0, ext_rvalid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] ext_rdata = '0, out_data;
  logic [2:0] fsm_state;

  operand_fetch_scheduler #(
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H), .INPUT_NB_CHANNELS(IC),
    .OUTPUT_NB_CHANNELS(OC), .LOG2_OF_MEM_HEIGHT(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .w_base(w_base), .a_base(a_base),
    .running(running), .done(done), .ext_req(ext_req), .ext_addr(ext_addr),
    .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .err(err), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  int xfers = 0, pops = 0, done_cnt = 0;
  int gnt_mode = 0, ready_mode = 0;   // 0 always high, 1 random, 2 held low
  bit inject_bad = 0, stall_prev = 0;
  logic [AW-1:0] stall_addr;
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_q[$];
  int            resp_due_q[$];
  logic [DW-1:0] resp_data_q[$];

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return a[15:0] ^ {a[19:16], 12'h5a3};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: consumption order written straight from the loop nest.
  task automatic build_ref(input logic [AW-1:0] wb, input logic [AW-1:0] ab);
    logic [31:0] full_addr;
    logic [AW-1:0] a;
    exp_addr_q.delete();
    exp_q.delete();
    for (int ci = 0; ci < IC; ci++) begin
      for (int k = 0; k < 2; k++) begin
        full_addr = 32'(wb) + 32'(2 * ci + k);
        a = full_addr[AW-1:0];
        exp_addr_q.push_back(a);
        exp_q.push_back(mem_word(a));
      end
      for (int x = 0; x < W; x++)
        for (int y = 0; y < H; y++)
          for (int co = 0; co < OC; co++)
            for (int k = 0; k < 2; k++) begin
              full_addr = 32'(ab) + 32'(2 * (((ci * W + x) * H + y) * OC + co) + k);
              a = full_addr[AW-1:0];
              exp_addr_q.push_back(a);
              exp_q.push_back(mem_word(a));
            end
    end
  endtask

  // driver: handshake inputs and the memory response pipe, updated just after each edge
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    ext_gnt   = (gnt_mode == 0) ? 1'b1 : (gnt_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    if (inject_bad) begin
      ext_rvalid = 1'b1;
      ext_rdata  = 16'hdead;
      inject_bad = 0;
    end else if (resp_due_q.size() > 0 && resp_due_q[0] <= cyc) begin
      ext_rvalid = 1'b1;
      ext_rdata  = resp_data_q.pop_front();
      void'(resp_due_q.pop_front());
    end else begin
      ext_rvalid = 1'b0;
      ext_rdata  = 16'($urandom);
    end
  end

  // monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (arst_n_in) begin
      if (stall_prev) begin
        check("addr_hold_req", ext_req, 1);
        check("addr_hold_addr", ext_addr, stall_addr);
      end
      stall_prev = ext_req && !ext_gnt;
      stall_addr = ext_addr;
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) check("unexpected_word", out_data, 32'hffff_ffff);
        else check("out_data", out_data, exp_q.pop_front());
      end
      if (ext_req && ext_gnt) begin
        xfers++;
        if (exp_addr_q.size() == 0) check("unexpected_request", ext_addr, 32'hffff_ffff);
        else check("ext_addr", ext_addr, exp_addr_q.pop_front());
        resp_due_q.push_back(cyc + LAT);
        resp_data_q.push_back(mem_word(ext_addr));
        check("credit_inflight", (xfers - pops) <= DEPTH, 1);
      end
      if (done) done_cnt++;
    end
  end

  task automatic start_run(input logic [AW-1:0] wb, input logic [AW-1:0] ab);
    build_ref(wb, ab);
    xfers = 0; pops = 0; done_cnt = 0;
    w_base = wb; a_base = ab; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("running_after_start", running, 1);
    check("err_after_start", err, 0);
    check("first_req", ext_req, 1);
    check("first_addr", ext_addr, wb);
  endtask

  task automatic finish_run(input logic exp_err);
    int n = 0;
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("done_within_budget", done_cnt > 0, 1);
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt, 1);
    check("words_popped", pops, WORDS);
    check("words_requested", xfers, WORDS);
    check("words_left", exp_q.size(), 0);
    check("running_after_done", running, 0);
    check("err_at_end", err, exp_err);
  endtask

  task automatic check_reset_values();
    check("rst_running", running, 0);
    check("rst_done", done, 0);
    check("rst_ext_req", ext_req, 0);
    check("rst_ext_addr", ext_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_err", err, 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_reset_values();
    arst_n_in = 1'b1;
    repeat (2) @(negedge clk);

    // nominal stream
    start_run(20'h00100, 20'h01000);
    finish_run(1'b0);

    // consumer blocked: credits cap the requests, then release
    ready_mode = 2;
    start_run(20'h00100, 20'h01000);
    repeat (40) @(negedge clk);
    check("credit_xfers", xfers, DEPTH);
    check("credit_req_low", ext_req, 0);
    ready_mode = 0;
    finish_run(1'b0);

    // random grant and ready stalls
    gnt_mode = 1; ready_mode = 1;
    start_run(20'h00100, 20'h01000);
    finish_run(1'b0);

    // activation region wrapping past the top of memory
    start_run(20'h00040, 20'hffffc);
    finish_run(1'b0);

    // stray response with nothing outstanding
    gnt_mode = 2; ready_mode = 0;
    start_run(20'($urandom), 20'($urandom));
    repeat (2) @(negedge clk);
    check("err_before_stray", err, 0);
    inject_bad = 1;
    repeat (2) @(negedge clk);
    check("err_after_stray", err, 1);
    check("stray_not_pushed", out_valid, 0);
    gnt_mode = 1; ready_mode = 1;
    finish_run(1'b1);

    // random bases; start must clear err
    start_run(20'($urandom), 20'($urandom));
    finish_run(1'b0);

    // reset in the middle of activation issue with a partly filled FIFO
    gnt_mode = 0; ready_mode = 2;
    start_run(20'h00100, 20'h01000);
    n = 0;
    while (xfers < 6 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reached_mid_run", xfers >= 6, 1);
    #2 arst_n_in = 1'b0;
    #1 check_reset_values();
    exp_addr_q.delete(); exp_q.delete(); resp_due_q.delete(); resp_data_q.delete();
    stall_prev = 0; ready_mode = 0;
    repeat (3) @(negedge clk);
    arst_n_in = 1'b1;
    repeat (2) @(negedge clk);
    start_run(20'h00100, 20'h01000);
    finish_run(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog expired at t=%0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
